stop_watch_param_amisha: RTL and testbench

Parametrised successor to the three-digit BCD stopwatch. It provides an N-digit BCD up/down counter, advanced by a programmable prescaler tick. Adds a countdown preload, lap-capture display freeze, a sticky overflow flag and a countdown-expired flag. It sits between the board clock domain and the seven-segment display multiplexer; all digits are exported on one flat bus.

---
 rtl/stop_watch_pkg_amisha.sv | 16 +
 rtl/stop_watch_param_amisha_digit.sv | 33 +++
 rtl/stop_watch_param_amisha.sv | 97 +++++++++
 tb/tb_stop_watch_param_amisha.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/stop_watch_pkg_amisha.sv
// Shared BCD constants and per-digit helpers for the parametrised stopwatch.
package stop_watch_pkg_amisha;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   function automatic logic [3:0] bcd_step(input logic [3:0] v, input logic up);
      if (up) return (v >= BCD_MAX) ? BCD_MIN : v + 4'd1;
      else    return (v == BCD_MIN) ? BCD_MAX : v - 4'd1;
   endfunction

   function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction

endpackage

// File: rtl/stop_watch_param_amisha_digit.sv
// One BCD digit register; term_o flags the digit that carries/borrows into the next.
module bcd_digit_amisha
   import stop_watch_pkg_amisha::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       clr_i,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       en_i,
   input  logic       up_i,
   output logic [3:0] val_o,
   output logic       term_o
);

   logic [3:0] val_q, val_d;

   always_comb begin
      val_d = val_q;
      if (clr_i)       val_d = BCD_MIN;
      else if (load_i) val_d = bcd_clamp(load_val_i);
      else if (en_i)   val_d = bcd_step(val_q, up_i);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) val_q <= BCD_MIN;
      else         val_q <= val_d;
   end

   assign val_o  = val_q;
   assign term_o = up_i ? (val_q == BCD_MAX) : (val_q == BCD_MIN);

endmodule

// File: rtl/stop_watch_param_amisha.sv
// N-digit BCD up/down stopwatch with prescaler, preload, lap freeze and sticky flags.
module stop_watch_param_amisha
   import stop_watch_pkg_amisha::*;
#(
   parameter int DVSR = 5000000,
   parameter int NDIG = 4,
   parameter int PW   = 23
) (
   input  logic              clk_amisha,
   input  logic              reset_amisha,
   input  logic              go_amisha,
   input  logic              clr_amisha,
   input  logic              up_amisha,
   input  logic              load_amisha,
   input  logic [4*NDIG-1:0] load_val_amisha,
   input  logic              lap_amisha,
   output logic [4*NDIG-1:0] digits_amisha,
   output logic              ovf_amisha,
   output logic              zero_amisha,
   output logic              lap_mode_amisha
);

   localparam logic [PW-1:0] MS_END = PW'(DVSR - 1);

   logic [PW-1:0]           ms_q, ms_d;
   logic [NDIG-1:0][3:0]    cnt;
   logic [NDIG-1:0]         term, en;
   logic [4*NDIG-1:0]       disp_q;
   logic                    ovf_q, zero_q, lap_q;
   logic                    at_end, all_zero, is_one, halted, tick, step, wrap, reach_zero;

   assign at_end   = (ms_q == MS_END);
   assign all_zero = (cnt == '0);
   assign is_one   = (cnt == (4*NDIG)'(1));
   assign halted   = ~up_amisha & zero_q & all_zero;
   assign tick     = go_amisha & at_end & ~halted;
   // A down tick at 0000 only raises zero; it must not borrow round to all-9s.
   assign step       = tick & ~(~up_amisha & all_zero);
   assign wrap       = tick & up_amisha & (&term);
   assign reach_zero = tick & ~up_amisha & (all_zero | is_one);

   for (genvar i = 0; i < NDIG; i++) begin : g_dig
      if (i == 0) begin : g_first
         assign en[i] = step;
      end else begin : g_rest
         assign en[i] = step & (&term[i-1:0]);
      end

      bcd_digit_amisha u_dig (
         .clk_i      (clk_amisha),
         .reset_i    (reset_amisha),
         .clr_i      (clr_amisha),
         .load_i     (load_amisha),
         .load_val_i (load_val_amisha[4*i +: 4]),
         .en_i       (en[i]),
         .up_i       (up_amisha),
         .val_o      (cnt[i]),
         .term_o     (term[i])
      );
   end

   always_comb begin
      ms_d = ms_q;
      if (clr_amisha || load_amisha) ms_d = '0;
      else if (go_amisha)            ms_d = at_end ? '0 : ms_q + 1'b1;
   end

   always_ff @(posedge clk_amisha) begin
      if (reset_amisha) begin
         ms_q   <= '0;
         disp_q <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         lap_q  <= 1'b0;
      end else begin
         ms_q <= ms_d;
         if (!lap_q) disp_q <= cnt;
         if (clr_amisha)      lap_q <= 1'b0;
         else if (lap_amisha) lap_q <= ~lap_q;
         if (clr_amisha) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
         end else if (load_amisha) begin
            zero_q <= 1'b0;
         end else begin
            if (wrap)       ovf_q  <= 1'b1;
            if (reach_zero) zero_q <= 1'b1;
         end
      end
   end

   assign digits_amisha   = disp_q;
   assign ovf_amisha      = ovf_q;
   assign zero_amisha     = zero_q;
   assign lap_mode_amisha = lap_q;

endmodule

// File: tb/tb_stop_watch_param_amisha.sv
// Phase-table stimulus with an integer reference model feeding a per-cycle scoreboard.
module tb_stop_watch_param_amisha;

   localparam int DVSR = 4;
   localparam int NDIG = 3;
   localparam int PW   = 3;
   localparam int W    = 4 * NDIG;
   localparam int MAXV = 999;

   logic         clk = 1'b0;
   logic         rst = 1'b1, go = 1'b0, clr = 1'b0, up = 1'b0, ld = 1'b0, lap = 1'b0;
   logic [W-1:0] lv = '0;
   logic [W-1:0] dig;
   logic         ovf, zero, lapm;

   always #5 clk = ~clk;

   stop_watch_param_amisha #(.DVSR(DVSR), .NDIG(NDIG), .PW(PW)) dut (
      .clk_amisha      (clk),
      .reset_amisha    (rst),
      .go_amisha       (go),
      .clr_amisha      (clr),
      .up_amisha       (up),
      .load_amisha     (ld),
      .load_val_amisha (lv),
      .lap_amisha      (lap),
      .digits_amisha   (dig),
      .ovf_amisha      (ovf),
      .zero_amisha     (zero),
      .lap_mode_amisha (lapm)
   );

   typedef struct {
      logic rst, go, clr, up, ld, lap;
      logic [W-1:0] lv;
      int n;
      logic [W-1:0] e_dig;
      logic e_ovf, e_zero, e_lap;
   } vec_t;

   typedef struct {
      logic [W-1:0] dig;
      logic ovf, zero, lap;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   m_cnt, m_ms, m_disp;
   bit   m_ovf, m_zero, m_lap;
   int   checks = 0, fails = 0, cyc = 0;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < NDIG; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int from_bcd_clamped(input logic [W-1:0] b);
      int r, d;
      r = 0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         d = int'(b[4*i +: 4]);
         if (d > 9) d = 9;
         r = r * 10 + d;
      end
      return r;
   endfunction

   function automatic vec_t mk(input logic r, g, c, u, l, lp, input logic [W-1:0] v,
                               input int n, input logic [W-1:0] ed, input logic eo, ez, el);
      vec_t x;
      x.rst = r; x.go = g; x.clr = c; x.up = u; x.ld = l; x.lap = lp; x.lv = v; x.n = n;
      x.e_dig = ed; x.e_ovf = eo; x.e_zero = ez; x.e_lap = el;
      return x;
   endfunction

   task automatic model_step(input vec_t v);
      bit tick, halted;
      if (v.rst) begin
         m_cnt = 0; m_ms = 0; m_disp = 0; m_ovf = 0; m_zero = 0; m_lap = 0;
         return;
      end
      halted = !v.up && m_zero && (m_cnt == 0);
      tick   = v.go && (m_ms == DVSR - 1) && !halted;
      if (!m_lap) m_disp = m_cnt;
      if (v.clr)      m_lap = 0;
      else if (v.lap) m_lap = !m_lap;
      if (v.clr) begin
         m_cnt = 0; m_ms = 0; m_ovf = 0; m_zero = 0;
      end else if (v.ld) begin
         m_cnt = from_bcd_clamped(v.lv); m_ms = 0; m_zero = 0;
      end else begin
         if (v.go) m_ms = (m_ms + 1) % DVSR;
         if (tick) begin
            if (v.up) begin
               if (m_cnt == MAXV) begin m_cnt = 0; m_ovf = 1; end
               else m_cnt = m_cnt + 1;
            end else begin
               if (m_cnt > 0) m_cnt = m_cnt - 1;
               if (m_cnt == 0) m_zero = 1;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [W-1:0] ed, input logic eo, ez, el);
      checks++;
      if ({dig, ovf, zero, lapm} !== {ed, eo, ez, el}) begin
         fails++;
         $display("FAIL %s cyc=%0d got dig=%h ovf=%b zero=%b lap=%b want dig=%h ovf=%b zero=%b lap=%b",
                  name, cyc, dig, ovf, zero, lapm, ed, eo, ez, el);
      end
   endtask

   // Drive one cycle at the negedge, predict, then compare after the edge.
   task automatic apply(input vec_t v);
      exp_t e;
      rst = v.rst; go = v.go; clr = v.clr; up = v.up; ld = v.ld; lap = v.lap; lv = v.lv;
      model_step(v);
      e.dig = to_bcd(m_disp); e.ovf = m_ovf; e.zero = m_zero; e.lap = m_lap;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      e = sb.pop_front();
      check("scoreboard", e.dig, e.ovf, e.zero, e.lap);
   endtask

   initial begin
      tbl.push_back(mk(1,0,0,0,0,0,'h000,   2,'h000,0,0,0)); // reset
      tbl.push_back(mk(0,1,0,1,0,0,'h000,4001,'h000,1,0,0)); // 000..999 then wrap
      tbl.push_back(mk(0,1,0,1,0,0,'h000,   8,'h002,1,0,0)); // ovf sticky
      tbl.push_back(mk(0,1,1,1,0,0,'h000,   1,'h002,0,0,0)); // clr
      tbl.push_back(mk(0,1,0,1,0,0,'h000,   6,'h001,0,0,0)); // pause test: run 6
      tbl.push_back(mk(0,0,0,1,0,0,'h000,  20,'h001,0,0,0)); //   hold 20
      tbl.push_back(mk(0,1,0,1,0,0,'h000,   2,'h001,0,0,0)); //   run 2
      tbl.push_back(mk(0,0,0,1,0,0,'h000,   1,'h002,0,0,0)); //   exactly two ticks
      tbl.push_back(mk(0,1,0,0,1,0,'h012,   1,'h002,0,0,0)); // load 012
      tbl.push_back(mk(0,1,0,0,0,0,'h000,  48,'h001,0,1,0)); // count down to 000
      tbl.push_back(mk(0,1,0,0,0,0,'h000,  12,'h000,0,1,0)); // expired holds
      tbl.push_back(mk(0,0,1,0,0,0,'h000,   1,'h000,0,0,0)); // clr
      tbl.push_back(mk(0,1,0,1,0,0,'h000, 100,'h024,0,0,0)); // count to 025
      tbl.push_back(mk(0,1,0,1,0,1,'h000,   1,'h025,0,0,1)); // lap on
      tbl.push_back(mk(0,1,0,1,0,0,'h000,  59,'h025,0,0,1)); // frozen, counter to 040
      tbl.push_back(mk(0,0,0,1,0,1,'h000,   1,'h025,0,0,0)); // lap off
      tbl.push_back(mk(0,0,0,1,0,0,'h000,   1,'h040,0,0,0)); // display catches up
      tbl.push_back(mk(0,1,0,1,1,0,'h999,   1,'h040,0,0,0)); // load 999
      tbl.push_back(mk(0,1,0,1,0,0,'h000,   4,'h999,1,0,0)); // wrap sets ovf
      tbl.push_back(mk(0,0,0,1,1,0,'h333,   1,'h000,1,0,0)); // load keeps ovf
      tbl.push_back(mk(0,0,0,1,0,0,'h000,   1,'h333,1,0,0));
      tbl.push_back(mk(0,0,1,1,1,0,'h777,   1,'h333,0,0,0)); // clr beats load
      tbl.push_back(mk(0,0,0,1,0,0,'h000,   1,'h000,0,0,0));
      tbl.push_back(mk(0,0,0,1,1,0,'h0A5,   1,'h000,0,0,0)); // clamp A->9
      tbl.push_back(mk(0,0,0,1,0,0,'h000,   1,'h095,0,0,0));
      tbl.push_back(mk(0,0,0,1,1,0,'hF3C,   1,'h095,0,0,0)); // clamp F,C->9
      tbl.push_back(mk(0,0,0,1,0,0,'h000,   1,'h939,0,0,0));
      tbl.push_back(mk(0,1,0,0,1,0,'h000,   1,'h939,0,0,0)); // load 000, down
      tbl.push_back(mk(0,1,0,0,0,0,'h000,   4,'h000,0,1,0)); // no wrap, zero set
      tbl.push_back(mk(0,1,0,1,0,0,'h000,   4,'h000,0,1,0)); // up resumes
      tbl.push_back(mk(0,0,0,1,0,0,'h000,   1,'h001,0,1,0));
      tbl.push_back(mk(0,1,0,1,1,0,'h999,   1,'h001,0,0,0));
      tbl.push_back(mk(0,1,0,1,0,0,'h000,   4,'h999,1,0,0));
      tbl.push_back(mk(0,1,0,1,1,0,'h516,   1,'h000,1,0,0));
      tbl.push_back(mk(0,1,0,1,0,0,'h000,   4,'h516,1,0,0)); // reach 517
      tbl.push_back(mk(0,1,0,1,0,1,'h000,   1,'h517,1,0,1)); // lap on
      tbl.push_back(mk(0,1,0,1,0,0,'h000,   2,'h517,1,0,1)); // tick now due
      tbl.push_back(mk(1,1,0,1,0,0,'h000,   1,'h000,0,0,0)); // reset discards it
      tbl.push_back(mk(0,0,0,1,0,0,'h000,   1,'h000,0,0,0));

      @(negedge clk);
      foreach (tbl[k]) begin
         for (int c = 0; c < tbl[k].n; c++) apply(tbl[k]);
         check($sformatf("phase%0d", k), tbl[k].e_dig, tbl[k].e_ovf, tbl[k].e_zero, tbl[k].e_lap);
      end

      // lap and clr together: clr must win
      apply(mk(0,0,0,1,0,1,'h000,1,'h000,0,0,0));
      check("lap_set", 'h000, 1'b0, 1'b0, 1'b1);
      apply(mk(0,0,1,1,0,1,'h000,1,'h000,0,0,0));
      check("lap_clr_same_cycle", 'h000, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
